// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V width codes, FSM states
// and the accept-time legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MERGE,
        WRITE,
        RESP
    } lsu_state_e;

    // Unsigned widths only exist for loads, and every access must be naturally aligned.
    function automatic logic lsu_is_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] byte_off);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = byte_off[0];
            F3_W:    err = (byte_off != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | byte_off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: extracts and extends load data, and
// merges sub-word store data into a full memory word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] mem_word,
    input  logic [15:0]     store_data,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = mem_word[{byte_off, 3'b000} +: 8];
        half_sel    = mem_word[{byte_off[1], 4'b0000} +: 16];
        load_data   = '0;
        merged_word = mem_word;

        case (funct3)
            F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = mem_word;
        endcase

        // Only sub-word stores pass through the merge; word stores bypass it.
        case (funct3)
            F3_B:    merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
            F3_H:    merged_word[{byte_off[1], 4'b0000} +: 16] = store_data;
            default: merged_word = mem_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks legality, performs read-modify-write
// for sub-word stores and returns a held response to the pipeline.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged_word;
    logic            unused_mem_words;

    assign unused_mem_words = (MEM_WORDS > 0);

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3      (funct3_q),
        .byte_off    (addr_q[1:0]),
        .mem_word    (mem_rdata),
        .store_data  (buf_q[15:0]),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        err_d    = err_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        buf_d    = buf_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    buf_d    = req_wdata;
                    rdata_d  = '0;
                    err_d    = lsu_is_err(req_we, req_funct3, req_addr[1:0]);
                    if (err_d) begin
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_data;
                state_d = RESP;
            end
            MERGE: begin
                buf_d   = merged_word;
                state_d = WRITE;
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            buf_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            err_q    <= err_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            buf_q    <= buf_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs decode the registered state and are forced quiet while reset is held,
    // so a WRITE in flight when reset arrives never reaches memory.
    always_comb begin
        req_ready = !rst && (state_q == IDLE);
        rsp_valid = !rst && (state_q == RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !err_q && !we_q) ? rdata_q : '0;
        mem_read  = !rst && ((state_q == LOAD) || (state_q == MERGE));
        mem_write = !rst && (state_q == WRITE);
        mem_addr  = (mem_read || mem_write) ? {addr_q[XLEN-1:2], 2'b00} : '0;
        mem_wdata = mem_write ? buf_q : '0;
    end

endmodule
